// File: rtl/bp_pkg.sv
// Shared constants for the branch predictor: branch class codes, MIPS opcode and
// funct fields, and the 2-bit saturating counter states.
package bp_pkg;

  typedef enum logic [3:0] {
    CLS_NONE    = 4'd0,
    CLS_BEQ     = 4'd1,
    CLS_BNE     = 4'd2,
    CLS_BGEZ    = 4'd3,
    CLS_BLEZ    = 4'd4,
    CLS_BGTZ    = 4'd5,
    CLS_BLTZ    = 4'd6,
    CLS_J       = 4'd7,
    CLS_JR      = 4'd8,
    CLS_BLEZALR = 4'd9
  } br_class_e;

  localparam logic [5:0] OP_SPECIAL = 6'd0;
  localparam logic [5:0] OP_REGIMM  = 6'd1;
  localparam logic [5:0] OP_J       = 6'd2;
  localparam logic [5:0] OP_JAL     = 6'd3;
  localparam logic [5:0] OP_BEQ     = 6'd4;
  localparam logic [5:0] OP_BNE     = 6'd5;
  localparam logic [5:0] OP_BLEZ    = 6'd6;
  localparam logic [5:0] OP_BGTZ    = 6'd7;
  localparam logic [5:0] OP_BLEZALR = 6'd24;

  localparam logic [5:0] FN_JR   = 6'd8;
  localparam logic [5:0] FN_JALR = 6'd9;

  localparam logic [4:0] RT_BLTZ = 5'd0;
  localparam logic [4:0] RT_BGEZ = 5'd1;

  localparam logic [1:0] SNT = 2'd0;
  localparam logic [1:0] WNT = 2'd1;
  localparam logic [1:0] WT  = 2'd2;
  localparam logic [1:0] ST  = 2'd3;

endpackage

// File: rtl/branch_predict_unit_if.sv
// Fetch/ID-side bundle of the branch predictor; master is the pipeline, slave is the unit.
interface branch_predict_unit_if #(parameter int CNT_W = 32);
  logic [31:0]      pc_if;
  logic             pred_taken_if;
  logic [31:0]      pred_target_if;
  logic             stall;
  logic             flush;
  logic             valid_id;
  logic [31:0]      pc_id;
  logic [31:0]      instr_id;
  logic [31:0]      rs_val;
  logic [31:0]      rt_val;
  logic             redirect;
  logic [31:0]      redirect_pc;
  logic [CNT_W-1:0] br_cnt;
  logic [CNT_W-1:0] miss_cnt;

  modport master (
    output pc_if, stall, flush, valid_id, pc_id, instr_id, rs_val, rt_val,
    input  pred_taken_if, pred_target_if, redirect, redirect_pc, br_cnt, miss_cnt
  );

  modport slave (
    input  pc_if, stall, flush, valid_id, pc_id, instr_id, rs_val, rt_val,
    output pred_taken_if, pred_target_if, redirect, redirect_pc, br_cnt, miss_cnt
  );
endinterface

// File: rtl/bp_resolve.sv
// ID-stage branch resolver: decodes the branch class, evaluates the condition on
// forwarded operands and computes the architectural target.
module bp_resolve
  import bp_pkg::*;
(
  input  logic [31:0] pc_id,
  input  logic [31:0] instr_id,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output br_class_e   cls,
  output logic        taken,
  output logic [31:0] target
);

  logic [5:0]         op;
  logic [4:0]         rt_fld;
  logic [5:0]         fn;
  logic signed [31:0] rs_s;
  logic signed [31:0] br_off;
  logic [31:0]        pc_plus4;

  assign op       = instr_id[31:26];
  assign rt_fld   = instr_id[20:16];
  assign fn       = instr_id[5:0];
  assign rs_s     = $signed(rs_val);
  assign br_off   = $signed({{14{instr_id[15]}}, instr_id[15:0], 2'b00});
  assign pc_plus4 = pc_id + 32'd4;

  always_comb begin
    cls = CLS_NONE;
    case (op)
      OP_SPECIAL: if (fn == FN_JR || fn == FN_JALR) cls = CLS_JR;
      OP_REGIMM: begin
        if (rt_fld == RT_BGEZ)      cls = CLS_BGEZ;
        else if (rt_fld == RT_BLTZ) cls = CLS_BLTZ;
      end
      OP_J, OP_JAL: cls = CLS_J;
      OP_BEQ:       cls = CLS_BEQ;
      OP_BNE:       cls = CLS_BNE;
      OP_BLEZ:      cls = CLS_BLEZ;
      OP_BGTZ:      cls = CLS_BGTZ;
      OP_BLEZALR:   cls = CLS_BLEZALR;
      default:      cls = CLS_NONE;
    endcase
  end

  always_comb begin
    taken  = 1'b0;
    target = 32'd0;
    case (cls)
      CLS_BEQ:     begin taken = (rs_val == rt_val); target = pc_plus4 + br_off; end
      CLS_BNE:     begin taken = (rs_val != rt_val); target = pc_plus4 + br_off; end
      CLS_BGEZ:    begin taken = (rs_s >= 32'sd0);   target = pc_plus4 + br_off; end
      CLS_BLEZ:    begin taken = (rs_s <= 32'sd0);   target = pc_plus4 + br_off; end
      CLS_BGTZ:    begin taken = (rs_s > 32'sd0);    target = pc_plus4 + br_off; end
      CLS_BLTZ:    begin taken = (rs_s < 32'sd0);    target = pc_plus4 + br_off; end
      CLS_J:       begin taken = 1'b1; target = {pc_plus4[31:28], instr_id[25:0], 2'b00}; end
      CLS_JR:      begin taken = 1'b1; target = rs_val; end
      CLS_BLEZALR: begin taken = (rs_s <= 32'sd0);   target = rt_val; end
      default:     begin taken = 1'b0; target = 32'd0; end
    endcase
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch target buffer with 2-bit counters: combinational IF lookup, one-cycle
// prediction carry into ID, resolution with redirect, and table training.
module branch_predict_unit
  import bp_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int CNT_W = 32
) (
  input logic                 clk,
  input logic                 reset,
  branch_predict_unit_if.slave bus
);

  localparam int IDX   = $clog2(DEPTH);
  localparam int TAG_W = 30 - IDX;

  logic             tab_vld [DEPTH];
  logic [TAG_W-1:0] tab_tag [DEPTH];
  logic [31:0]      tab_tgt [DEPTH];
  logic [1:0]       tab_ctr [DEPTH];

  logic             pred_taken_q;
  logic [31:0]      pred_target_q;
  logic [CNT_W-1:0] br_cnt_q;
  logic [CNT_W-1:0] miss_cnt_q;

  function automatic logic [1:0] ctr_next(input logic [1:0] c, input logic t);
    if (t) return (c == ST)  ? ST  : c + 2'd1;
    else   return (c == SNT) ? SNT : c - 2'd1;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // IF stage: zero-latency lookup
  logic [IDX-1:0]   idx_if;
  logic [TAG_W-1:0] tag_if;
  logic             hit_if;
  logic             unused_pc_if_lsb;

  assign idx_if               = bus.pc_if[IDX+1:2];
  assign tag_if               = bus.pc_if[31:IDX+2];
  assign hit_if               = tab_vld[idx_if] && (tab_tag[idx_if] == tag_if);
  assign bus.pred_taken_if    = hit_if && tab_ctr[idx_if][1];
  assign bus.pred_target_if   = hit_if ? tab_tgt[idx_if] : 32'd0;
  assign unused_pc_if_lsb     = ^bus.pc_if[1:0];

  // ID stage: resolve against the carried prediction
  br_class_e        cls;
  logic             taken;
  logic [31:0]      target;
  logic [IDX-1:0]   idx_id;
  logic [TAG_W-1:0] tag_id;
  logic             hit_id;
  logic             resolve;
  logic             mispredict;

  bp_resolve u_resolve (
    .pc_id    (bus.pc_id),
    .instr_id (bus.instr_id),
    .rs_val   (bus.rs_val),
    .rt_val   (bus.rt_val),
    .cls      (cls),
    .taken    (taken),
    .target   (target)
  );

  assign idx_id     = bus.pc_id[IDX+1:2];
  assign tag_id     = bus.pc_id[31:IDX+2];
  assign hit_id     = tab_vld[idx_id] && (tab_tag[idx_id] == tag_id);
  assign resolve    = bus.valid_id && !bus.stall && !bus.flush && !reset;
  assign mispredict = (pred_taken_q != taken) || (taken && (pred_target_q != target));

  assign bus.redirect    = resolve && mispredict;
  // Fall-through skips the delay slot, which fetch already holds.
  assign bus.redirect_pc = bus.redirect ? (taken ? target : bus.pc_id + 32'd8) : 32'd0;
  assign bus.br_cnt      = br_cnt_q;
  assign bus.miss_cnt    = miss_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      pred_taken_q  <= 1'b0;
      pred_target_q <= 32'd0;
      br_cnt_q      <= '0;
      miss_cnt_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tab_vld[i] <= 1'b0;
        tab_ctr[i] <= SNT;
      end
    end else begin
      if (bus.flush) begin
        pred_taken_q  <= 1'b0;
        pred_target_q <= 32'd0;
      end else if (!bus.stall) begin
        pred_taken_q  <= bus.pred_taken_if;
        pred_target_q <= bus.pred_target_if;
      end

      if (resolve) begin
        if (cls != CLS_NONE) begin
          br_cnt_q        <= sat_inc(br_cnt_q);
          tab_tgt[idx_id] <= target;
          if (hit_id) begin
            tab_ctr[idx_id] <= ctr_next(tab_ctr[idx_id], taken);
          end else begin
            tab_vld[idx_id] <= 1'b1;
            tab_tag[idx_id] <= tag_id;
            tab_ctr[idx_id] <= taken ? WT : WNT;
          end
        end else if (pred_taken_q && hit_id) begin
          // A non-branch that hit a taken entry is an alias; drop the entry.
          tab_vld[idx_id] <= 1'b0;
        end
        if (mispredict) miss_cnt_q <= sat_inc(miss_cnt_q);
      end
    end
  end

endmodule

// File: doc/branch_predict_unit.md
# branch_predict_unit

Parametrised branch target buffer (BTB) and predictor that generalises the ID-stage branch-class decoder into a predicting fetch path. The block looks up the IF-stage PC in a DEPTH-entry tagged table with 2-bit saturating counters. It carries the prediction across the IF/ID boundary and resolves the branch in ID against forwarded register values, raising a one-cycle redirect on a mispredict. It then trains the table. It sits between the fetch unit (pc_if in, pred out) and the ID stage (instruction and forwarded operands in, redirect out).

## Interface
- DEPTH, 64: table entries; power of two, 4..1024; IDX = log2(DEPTH)
- CNT_W, 32: width of the branch and mispredict performance counters
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- pc_if  in  32  PC being fetched
- pred_taken_if  out  1  combinational: hit && ctr[1]
- pred_target_if  out  32  combinational: entry target (0 on miss)
- stall  in  1  hold IF/ID: prediction registers keep value, no resolution, no training
- flush  in  1  clears prediction registers and suppresses resolution this cycle
- valid_id  in  1  instruction in ID is real
- pc_id  in  32  PC of the ID instruction
- instr_id  in  32  ID instruction word
- rs_val, rt_val  in  32 each  forwarded operands
- redirect  out  1  combinational mispredict in ID
- redirect_pc  out  32  correct PC for fetch to load
- br_cnt, miss_cnt  out  CNT_W each  saturating counters of resolved branches and redirects

## Operation
- Branch classes (shared codes, 4 bits):
  - 0 none
  - 1 beq (op 4)
  - 2 bne (op 5)
  - 3 bgez (op 1, rt 1)
  - 4 blez (op 6)
  - 5 bgtz (op 7)
  - 6 bltz (op 1, rt 0)
  - 7 j/jal (op 2/3)
  - 8 jr/jalr (op 0, fun 8/9)
  - 9 blezalr (op 24)
- Actual taken:
  - beq: rs==rt
  - bne: rs!=rt
  - signed compares of rs against 0 for classes 3–6 and 9 (blezalr: rs<=0)
  - classes 7, 8: always taken
- Targets:
  - classes 1–6: pc_id+4+(sext(imm16)<<2)
  - class 7: {pc_id+4[31:28], instr[25:0], 2'b00}
  - class 8: rs_val
  - class 9: rt_val
- Entry fields: valid, tag = pc[31:IDX+2], target[31:0], ctr[1:0]. Index = pc[IDX+1:2].
- Hit = valid && tag match.
- Prediction registers pred_taken_q and pred_target_q load pred_*_if when !stall && !flush; they clear to 0 on flush or reset.
- Resolution happens when valid_id && !stall && !flush:
  - mispredict = (pred_taken_q != taken) || (taken && pred_target_q != target)
  - redirect = mispredict
  - redirect_pc = taken ? target : pc_id+8 (the delay slot is already fetched)
- Training on resolution:
  - Class != 0, hit: target is rewritten. ctr increments (saturating at 3) if taken and decrements (saturating at 0) if not.
  - Class != 0, miss: the entry is allocated, overwriting any occupant. ctr = taken ? 2 : 1.
  - Class 0 with pred_taken_q=1 (alias): the entry is invalidated if its tag matches pc_id.
- br_cnt increments on every resolution with class != 0. miss_cnt increments on every redirect. Both hold at all-ones.

## Timing
- Lookup: zero latency, combinational from pc_if.
- IF to ID prediction: one register stage.
- Redirect: combinational in the ID cycle; at most one redirect per cycle.
- Table write: on the edge ending the resolving ID cycle.
- Same-cycle lookup and write to one index: the lookup returns the old contents (read-before-write).
- Reset clears all valid bits, ctrs, pred registers and perf counters. All outputs are 0 after reset.
- pred_*_if reads 0 until the first allocation.
- A reset mid-stream drops any pending resolution and does not train.
- stall and flush together: flush wins.

## Structure
- Shared package bp_pkg holds:
  - the class codes 0–9
  - the opcode/funct constants
  - the 2-bit counter constants (SNT=0, WNT=1, WT=2, ST=3)
- One sub-module, bp_resolve: combinational class decode, compare and target computation for the ID stage.
- The table stays in the top, as flat register arrays.

## Test plan
- Reset, then pc_if=0x3000: pred_taken_if=0, pred_target_if=0, br_cnt=0.
- beq at 0x3000, rs=rt=5, imm=4, cold table: redirect=1, redirect_pc=0x3014. Entry ctr=2. Next pc_if=0x3000 gives pred_taken_if=1, target 0x3014.
- The same beq then resolves not-taken three times: redirect_pc=0x3008 on the first, no redirect afterwards. ctr goes 2→1→0→0.
- jr with rs=0x4000 while the entry predicts 0x3014: redirect=1, redirect_pc=0x4000, target rewritten. The next occurrence does not redirect.
- DEPTH=4: PCs 0x3000 and 0x3010 alias. The second allocation evicts the first. A non-branch at 0x3000 with pred_taken_q=1 redirects to 0x3008 and invalidates the entry.
- stall=1 during a mispredicting beq: no redirect, no training, counters unchanged. flush=1: pred registers read 0 the next cycle.
